// File: rtl/pipe_stage_skid.sv
// Pipeline stage register {instr, currPC, nextPC} with valid/ready, flush-to-NOP and a stall counter.
// Latency 1 cycle; SKID=1 gives a 2-entry skid with registered in_ready, SKID=0 a single entry with in_ready from out_ready.
module pipe_stage_skid #(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter bit                 SKID      = 1'b1,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_curr_pc,
    input  logic [PC_W-1:0]    in_next_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_curr_pc,
    output logic [PC_W-1:0]    out_next_pc,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic accept;
    logic pop;
    logic headVld;
    logic loadHeadIn;
    logic loadHeadSkid;
    logic loadSkid;
    logic clearHead;

    logic [INSTR_W-1:0] headInstr;
    logic [PC_W-1:0]    headCurrPc;
    logic [PC_W-1:0]    headNextPc;
    logic [INSTR_W-1:0] skidInstr;
    logic [PC_W-1:0]    skidCurrPc;
    logic [PC_W-1:0]    skidNextPc;

    assign headVld = (state != EMPTY);
    assign accept  = in_valid & in_ready;
    assign pop     = headVld & out_ready;

    // FULL is unreachable with SKID=0 because in_ready blocks accept-without-pop.
    generate
        if (SKID) begin : gSkid
            assign in_ready = (state != FULL);
        end else begin : gSingle
            assign in_ready = !headVld | out_ready;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        loadHeadIn   = 1'b0;
        loadHeadSkid = 1'b0;
        loadSkid     = 1'b0;
        clearHead    = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    stateNext  = ONE;
                    loadHeadIn = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    loadHeadIn = 1'b1;
                end else if (accept) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (pop) begin
                    stateNext = EMPTY;
                    clearHead = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    stateNext    = ONE;
                    loadHeadSkid = 1'b1;
                end
            end
            default: begin
                stateNext = EMPTY;
                clearHead = 1'b1;
            end
        endcase
        // A flush discards everything held plus any same-cycle accept.
        if (flush) begin
            stateNext    = EMPTY;
            loadHeadIn   = 1'b0;
            loadHeadSkid = 1'b0;
            loadSkid     = 1'b0;
            clearHead    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headInstr  <= NOP_INSTR;
            headCurrPc <= '0;
            headNextPc <= '0;
        end else if (clearHead) begin
            headInstr  <= NOP_INSTR;
            headCurrPc <= '0;
            headNextPc <= '0;
        end else if (loadHeadIn) begin
            headInstr  <= in_instr;
            headCurrPc <= in_curr_pc;
            headNextPc <= in_next_pc;
        end else if (loadHeadSkid) begin
            headInstr  <= skidInstr;
            headCurrPc <= skidCurrPc;
            headNextPc <= skidNextPc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skidInstr  <= NOP_INSTR;
            skidCurrPc <= '0;
            skidNextPc <= '0;
        end else if (loadSkid) begin
            skidInstr  <= in_instr;
            skidCurrPc <= in_curr_pc;
            skidNextPc <= in_next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (headVld && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = headVld;
    assign out_instr   = headInstr;
    assign out_curr_pc = headCurrPc;
    assign out_next_pc = headNextPc;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (skid/CNT_W=8, single/CNT_W=8, skid/CNT_W=4) driven one at a time
// against a queue model of the stage contents and a saturating stall-count model.
module tb_pipe_stage_skid;
    localparam int W = 16;
    localparam logic [W-1:0] NOP = 16'h0800;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         inValid   [3];
    logic         outReady  [3];
    logic         inReady   [3];
    logic         outValid  [3];
    logic [W-1:0] outInstr  [3];
    logic [W-1:0] outCurrPc [3];
    logic [W-1:0] outNextPc [3];
    logic [W-1:0] inInstr;
    logic [W-1:0] inCurrPc;
    logic [W-1:0] inNextPc;
    logic         flush;
    logic [7:0]   stallCnt0;
    logic [7:0]   stallCnt1;
    logic [3:0]   stallCnt2;

    pipe_stage_skid #(.SKID(1'b1), .CNT_W(8)) uSkid (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_instr(inInstr), .in_curr_pc(inCurrPc), .in_next_pc(inNextPc), .flush(flush),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_instr(outInstr[0]),
        .out_curr_pc(outCurrPc[0]), .out_next_pc(outNextPc[0]), .stall_cnt(stallCnt0)
    );

    pipe_stage_skid #(.SKID(1'b0), .CNT_W(8)) uSingle (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_instr(inInstr), .in_curr_pc(inCurrPc), .in_next_pc(inNextPc), .flush(flush),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_instr(outInstr[1]),
        .out_curr_pc(outCurrPc[1]), .out_next_pc(outNextPc[1]), .stall_cnt(stallCnt1)
    );

    pipe_stage_skid #(.SKID(1'b1), .CNT_W(4)) uSat (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_instr(inInstr), .in_curr_pc(inCurrPc), .in_next_pc(inNextPc), .flush(flush),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_instr(outInstr[2]),
        .out_curr_pc(outCurrPc[2]), .out_next_pc(outNextPc[2]), .stall_cnt(stallCnt2)
    );

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int pops = 0;
    int stallExp = 0;
    logic [47:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int stallMax();
        return (sel == 2) ? 15 : 255;
    endfunction

    function automatic logic [7:0] getStall();
        case (sel)
            0:       return stallCnt0;
            1:       return stallCnt1;
            default: return {4'h0, stallCnt2};
        endcase
    endfunction

    task automatic drive(input logic v, input logic r, input logic [W-1:0] ins, input logic [W-1:0] cpc);
        inValid[sel]  = v;
        outReady[sel] = r;
        inInstr       = ins;
        inCurrPc      = cpc;
        inNextPc      = cpc + 16'd2;
    endtask

    // One clock: entered just after a falling edge with inputs already driven.
    task automatic cyc();
        logic modelVld;
        logic modelRdy;
        logic [47:0] head;
        #1;
        modelVld = (q.size() != 0);
        modelRdy = (sel == 1) ? (!modelVld || outReady[sel]) : (q.size() < 2);
        chk("out_valid", {63'd0, outValid[sel]}, {63'd0, modelVld});
        chk("in_ready", {63'd0, inReady[sel]}, {63'd0, modelRdy});
        head = modelVld ? q[0] : {NOP, 32'h0};
        chk("out_data", {16'h0, outInstr[sel], outCurrPc[sel], outNextPc[sel]}, {16'h0, head});
        if (modelVld && !outReady[sel] && !flush && stallExp < stallMax()) stallExp++;
        if (modelVld && outReady[sel]) begin
            void'(q.pop_front());
            pops++;
        end
        if (flush) q.delete();
        else if (inValid[sel] && modelRdy) q.push_back({inInstr, inCurrPc, inNextPc});
        @(posedge clk);
        @(negedge clk);
        chk("stall_cnt", {56'd0, getStall()}, stallExp);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic doReset();
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", {63'd0, outValid[i]}, 64'd0);
            chk("rst_out_instr", {48'd0, outInstr[i]}, {48'd0, NOP});
            chk("rst_pcs", {32'd0, outCurrPc[i], outNextPc[i]}, 64'd0);
            chk("rst_in_ready", {63'd0, inReady[i]}, 64'd1);
        end
        chk("rst_stall0", {56'd0, stallCnt0}, 64'd0);
        chk("rst_stall1", {56'd0, stallCnt1}, 64'd0);
        chk("rst_stall2", {60'd0, stallCnt2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        stallExp = 0;
        pops = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            inValid[i]  = 1'b0;
            outReady[i] = 1'b1;
        end
        inInstr  = '0;
        inCurrPc = '0;
        inNextPc = '0;
        flush    = 1'b0;
        doReset();

        // Reset while the skid stage is FULL and stalled.
        sel = 0;
        drive(1'b1, 1'b0, 16'hAAA0, 16'h0100); cyc();
        drive(1'b1, 1'b0, 16'hAAA1, 16'h0102); cyc();
        chk("full_before_rst", {63'd0, inReady[0]}, 64'd0);
        drive(1'b0, 1'b1, 16'h0, 16'h0);
        doReset();

        // Full-throughput stream.
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 16'h1000 + 16'(i), 16'(2 * i));
            cyc();
        end
        drive(1'b0, 1'b1, 16'h0, 16'h0); cyc(); cyc();
        chk("stream_pops", pops, 64'd16);

        // Backpressure: two entries absorbed, stall counts three cycles.
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'h2000 + 16'(i), 16'h0200 + 16'(2 * i));
            cyc();
        end
        chk("bp_stall3", {56'd0, stallCnt0}, 64'd3);
        drive(1'b0, 1'b1, 16'h0, 16'h0); cyc(); cyc(); cyc();
        chk("bp_pops", pops, 64'd2);
        chk("bp_drained", q.size(), 64'd0);

        // Flush while FULL with input valid, then flush with an accepted input.
        doReset();
        sel = 0;
        drive(1'b1, 1'b0, 16'h3000, 16'h0300); cyc();
        drive(1'b1, 1'b0, 16'h3001, 16'h0302); cyc();
        flush = 1'b1;
        drive(1'b1, 1'b0, 16'h3002, 16'h0304); cyc();
        chk("flush_valid", {63'd0, outValid[0]}, 64'd0);
        chk("flush_instr", {48'd0, outInstr[0]}, {48'd0, NOP});
        drive(1'b1, 1'b0, 16'h3003, 16'h0306); cyc();
        flush = 1'b0;
        drive(1'b1, 1'b1, 16'h3004, 16'h0308); cyc();
        drive(1'b0, 1'b1, 16'h0, 16'h0); cyc();
        chk("flush_stall", {56'd0, stallCnt0}, 64'd1);

        // Saturation with a 4-bit counter.
        doReset();
        sel = 2;
        drive(1'b1, 1'b0, 16'h4000, 16'h0400); cyc();
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_stall15", {60'd0, stallCnt2}, 64'd15);
        drive(1'b0, 1'b1, 16'h0, 16'h0); cyc(); cyc();
        chk("sat_hold", {60'd0, stallCnt2}, 64'd15);

        // Single-register stage with alternating downstream ready.
        doReset();
        sel = 1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'(i % 2), 16'h5000 + 16'(i), 16'h0500 + 16'(2 * i));
            cyc();
        end
        drive(1'b0, 1'b1, 16'h0, 16'h0); cyc(); cyc();
        chk("single_drained", q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
